// File: rtl/accum_window_capture_if.sv
// Handshake and MAC-side bus of accum_window_capture.
// The slave modport is the capture block; the master modport is its environment.
interface accum_window_capture_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
);
    logic               start;
    logic [CNTW-1:0]    len;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [WIDTH-1:0]   mac_a;
    logic [WIDTH-1:0]   mac_b;
    logic               mac_rst;
    logic [2*WIDTH-1:0] mac_res;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_sat;
    logic               busy;

    modport slave (
        input  start, len, in_valid, a_in, b_in, mac_res, out_ready,
        output in_ready, mac_a, mac_b, mac_rst, out_valid, out_data, out_sat, busy
    );

    modport master (
        output start, len, in_valid, a_in, b_in, mac_res, out_ready,
        input  in_ready, mac_a, mac_b, mac_rst, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/accum_window_capture.sv
// Sequences one window of operand pairs through an external pipelined MAC and
// captures the scaled, saturated sum into a held output register.
//
// state | meaning
// IDLE  | waiting for start; window length loaded on start
// CLEAR | one cycle of mac_rst to discard stale accumulator contents
// RUN   | accepting operand pairs until the length counter hits zero
// DRAIN | two cycles for the MAC operand and product registers to settle
// DONE  | mac_res final; capture when the output slot is free
module accum_window_capture #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8,
    parameter int SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    accum_window_capture_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNTW-1:0]  cnt, cnt_nxt;
    logic             drain, drain_nxt;
    logic             capture;
    logic             xfer;

    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_sat_q;
    logic [2*WIDTH-1:0] shifted;
    logic               capt_sat;
    logic [WIDTH-1:0]   capt_data;

    assign xfer = bus.in_valid && (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            drain <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            drain <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        drain_nxt = drain;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    cnt_nxt   = bus.len;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                drain_nxt = 1'b1;
                state_nxt = (cnt != '0) ? RUN : DRAIN;
            end
            RUN: begin
                if (xfer) begin
                    cnt_nxt = cnt - CNTW'(1);
                    if (cnt == CNTW'(1)) begin
                        drain_nxt = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // drain is a one-bit down-counter: 1 on entry, terminal at 0
                if (drain == 1'b0) begin
                    state_nxt = DONE;
                end else begin
                    drain_nxt = 1'b0;
                end
            end
            DONE: begin
                if (!out_valid_q || bus.out_ready) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready = (state == RUN);
    assign bus.mac_rst  = (state == CLEAR);
    assign bus.busy     = (state != IDLE);
    assign bus.mac_a    = xfer ? bus.a_in : '0;
    assign bus.mac_b    = xfer ? bus.b_in : '0;

    assign shifted   = bus.mac_res >> SHIFT;
    assign capt_sat  = |shifted[2*WIDTH-1:WIDTH];
    assign capt_data = capt_sat ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            out_data_q  <= capt_data;
            out_sat_q   <= capt_sat;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_accum_window_capture.sv
// Randomized and directed bench for accum_window_capture with a pipelined MAC
// model and a scoreboard of expected window results.
module tb_accum_window_capture;
    localparam int WIDTH = 8;
    localparam int CNTW  = 8;
    localparam int SHIFT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    accum_window_capture_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    accum_window_capture #(.WIDTH(WIDTH), .CNTW(CNTW), .SHIFT(SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Downstream MAC: operand register, product register, accumulator; only
    // mac_rst clears it, so stale sums survive a block reset.
    logic [WIDTH-1:0]   op_a = '0, op_b = '0;
    logic [2*WIDTH-1:0] prod = 16'h0123, acc = 16'hBEEF;
    always @(posedge clk) begin
        if (bus.mac_rst) begin
            op_a <= '0; op_b <= '0; prod <= '0; acc <= '0;
        end else begin
            op_a <= bus.mac_a;
            op_b <= bus.mac_b;
            prod <= (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);
            acc  <= acc + prod;
        end
    end
    assign bus.mac_res = acc;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  exp_q[$];
    int  wa[16], wb[16], wg[16];
    bit  rnd_ready = 1'b0;
    bit  ready_dir = 1'b1;
    bit  noise = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact sum of products, wrapped to the MAC width, then scaled.
    function automatic void ref_window(input int n, output int data, output int sat,
                                       output int wrapped);
        longint s = 0;
        longint sh;
        for (int i = 0; i < n; i++) s += longint'(wa[i]) * longint'(wb[i]);
        wrapped = int'(s % (64'd1 << (2*WIDTH)));
        sh = longint'(wrapped) >> SHIFT;
        if (sh > (1 << WIDTH) - 1) begin
            data = (1 << WIDTH) - 1; sat = 1;
        end else begin
            data = int'(sh); sat = 0;
        end
    endfunction

    initial forever begin
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_dir;
        @(posedge clk); #1;
    end

    // Monitor: pops on every output transfer and checks hold stability.
    bit               hold_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic             prev_sat;
    always @(negedge clk) begin
        if (!rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", {bus.out_sat, bus.out_data}, {prev_sat, prev_data});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", exp_q.size(), 1);
                else check("result", longint'(bus.out_sat) * 65536 + bus.out_data,
                           exp_q.pop_front());
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_sat  = bus.out_sat;
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_mac_rst"}, bus.mac_rst, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"}, {bus.out_sat, bus.out_data}, 0);
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (bus.busy && k < 200) begin @(negedge clk); k++; end
        if (bus.busy) check("idle_timeout", bus.busy, 0);
    endtask

    task automatic drive_noise();
        bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.len   = CNTW'($urandom);
    endtask

    task automatic run_window(input int n, input int exp_lat, input bit push_exp);
        int data, sat, wr, start_c, k, saw;
        bit done;
        ref_window(n, data, sat, wr);
        wait_idle();
        if (push_exp) exp_q.push_back(sat * 65536 + data);
        bus.start = 1'b1;
        bus.len   = CNTW'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        start_c = cyc;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < wg[i]; g++) begin
                drive_noise();
                bus.in_valid = 1'b0;
                bus.a_in = WIDTH'($urandom);
                bus.b_in = WIDTH'($urandom);
                @(negedge clk);
                check("gap_mac", (longint'(bus.mac_a) << WIDTH) | bus.mac_b, 0);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.a_in = WIDTH'(wa[i]);
            bus.b_in = WIDTH'(wb[i]);
            done = 1'b0;
            k = 0;
            while (!done && k < 50) begin
                drive_noise();
                @(negedge clk);
                if (bus.in_ready) begin
                    check("mac_pass", (longint'(bus.mac_a) << WIDTH) | bus.mac_b,
                          (longint'(wa[i]) << WIDTH) | wb[i]);
                    done = 1'b1;
                end
                @(posedge clk); #1;
                k++;
            end
            if (!done) check("in_ready_timeout", 0, 1);
        end
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        if (exp_lat >= 0) begin
            k = 0;
            saw = 0;
            while (!bus.out_valid && k < 60) begin
                @(negedge clk);
                if (bus.in_ready) saw = 1;
                k++;
            end
            if (!bus.out_valid) check("valid_timeout", 0, 1);
            else begin
                check("latency", cyc - start_c, exp_lat);
                check("mac_res", bus.mac_res, wr);
            end
            if (n == 0) check("len0_in_ready", saw, 0);
        end
    endtask

    initial begin
        int k;
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
        bus.a_in = '0; bus.b_in = '0;
        #2 bus.start = 1'b1;
        #10 reset_checks("rst");
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        reset_checks("post_rst");

        // len=3 back-to-back: sum 126 -> 7
        wa[0:2] = '{2, 4, 10}; wb[0:2] = '{3, 5, 10}; wg[0:2] = '{0, 0, 0};
        run_window(3, 7, 1);
        // wrap-around saturation: 64514 -> 255, sat
        wa[0:1] = '{255, 255}; wb[0:1] = '{255, 255}; wg[0:1] = '{0, 0};
        run_window(2, 6, 1);
        // one-cycle bubbles between pairs, two in total
        wa[0:2] = '{2, 4, 10}; wb[0:2] = '{3, 5, 10}; wg[0:2] = '{0, 1, 1};
        run_window(3, 9, 1);
        // empty window
        run_window(0, 4, 1);

        // output stalled: second window parks in DONE
        ready_dir = 1'b0;
        @(posedge clk); #1;
        wa[0:2] = '{2, 4, 10}; wb[0:2] = '{3, 5, 10}; wg[0:2] = '{0, 0, 0};
        run_window(3, 7, 1);
        wa[0] = 1; wb[0] = 48; wg[0] = 0;
        run_window(1, -1, 1);
        repeat (10) @(posedge clk);
        #1;
        check("stall_busy", bus.busy, 1);
        check("stall_data", bus.out_data, 7);
        ready_dir = 1'b1;
        wait_idle();

        // abort mid-window, then a fresh window must not see the stale sum
        wait_idle();
        bus.start = 1'b1; bus.len = CNTW'(3);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.a_in = 2; bus.b_in = 3;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            k++;
            if (bus.in_ready) break;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1 reset_checks("abort");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        wa[0] = 16; wb[0] = 1; wg[0] = 0;
        run_window(1, 5, 1);

        // randomized windows with random backpressure and ignored starts
        rnd_ready = 1'b1;
        noise = 1'b1;
        for (int w = 0; w < 25; w++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                wa[i] = $urandom_range(0, 255);
                wb[i] = $urandom_range(0, 255);
                wg[i] = $urandom_range(0, 2);
            end
            run_window(n, -1, 1);
        end
        noise = 1'b0;
        rnd_ready = 1'b0;
        ready_dir = 1'b1;
        wait_idle();
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin @(negedge clk); k++; end
        check("pending_results", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/accum_window_capture.md
ACCUM_WINDOW_CAPTURE -- requirements
Module: accum_window_capture

Interface
REQ-001 Parameter WIDTH, default 8: MAC operand width; MAC result width is 2*WIDTH.
REQ-002 Parameter CNTW, default 8: width of the window-length counter.
REQ-003 Parameter SHIFT, default 4: right-shift applied to the captured sum before saturation, range 0..WIDTH.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request a new accumulation window, sampled in IDLE only.
REQ-007 len  input  CNTW  number of operand pairs in the window, sampled with start.
REQ-008 in_valid / in_ready  input / output  1 / 1  operand handshake; a pair transfers when both are high.
REQ-009 a_in, b_in  input  WIDTH  unsigned operand pair from upstream.
REQ-010 mac_a, mac_b  output  WIDTH  operands to the downstream registered-operand multiply-accumulator.
REQ-011 mac_rst  output  1  active-high synchronous clear to the multiply-accumulator.
REQ-012 mac_res  input  2*WIDTH  accumulator value from the multiply-accumulator.
REQ-013 out_valid / out_ready  output / input  1 / 1  result handshake; a result transfers when both are high.
REQ-014 out_data  output  WIDTH  scaled, saturated window sum.
REQ-015 out_sat  output  1  high with out_data when saturation occurred.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, CLEAR, RUN, DRAIN and DONE, held in registers.
REQ-018 IDLE: start=1 SHALL load the counter with len and move to CLEAR; start in any other state SHALL be ignored.
REQ-019 CLEAR: lasts exactly one cycle with mac_rst=1; the next state SHALL be RUN if len!=0, else DRAIN.
REQ-020 mac_rst SHALL be 1 only in CLEAR, decoded from the state register (glitch-free).
REQ-021 in_ready SHALL be 1 only in RUN; each transfer decrements the counter, and the transfer that brings it to 0 SHALL move to DRAIN.
REQ-022 mac_a/mac_b SHALL equal a_in/b_in when in_valid and in_ready are both 1, and 0 otherwise; bubbles and idle cycles therefore add zero to the accumulator.
REQ-023 DRAIN SHALL last exactly 2 cycles, which covers the MAC operand-register and product-register stages, then move to DONE.
REQ-024 DONE: mac_res is final; when out_valid=0 or out_ready=1, the block SHALL capture the result into the output register, set out_valid=1 and go to IDLE. Otherwise it SHALL hold DONE with busy=1.
REQ-025 Capture: s = mac_res >> SHIFT (logical); out_data = s if s <= 2^WIDTH-1, else 2^WIDTH-1 with out_sat=1.
REQ-026 out_valid SHALL clear on a transfer unless a capture occurs in the same cycle; out_data and out_sat SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Latency: for a window of len, the result SHALL become valid len+4 cycles after start is accepted (no bubbles, output slot free); for len=0 it SHALL become valid after 4 cycles with out_data=0.
REQ-028 Wrap-around of the 2*WIDTH accumulator inside the MAC is not detected; out_sat reflects only the captured value.

Reset
REQ-029 While rst=0, the block SHALL force: state IDLE, counter 0, out_valid 0, out_data 0, out_sat 0, in_ready 0, mac_rst 0, busy 0.
REQ-030 Reset mid-window SHALL abort the window without producing a result; the next window's CLEAR SHALL discard stale MAC contents.

Verification
REQ-031 WIDTH=8, SHIFT=4, len=3, pairs (2,3),(4,5),(10,10) back-to-back -> sum 126, out_data=7, out_sat=0, out_valid exactly 7 cycles after start.
REQ-032 len=2, pairs (255,255) twice -> mac_res=64514 after wrap, out_data=255, out_sat=1.
REQ-033 len=3 with in_valid low for 2 cycles between pairs -> same result as REQ-031, latency +2, mac_a/mac_b=0 during the gaps.
REQ-034 out_ready=0; run two windows (results 7 and 3) -> the first result is held stable, the second window waits in DONE with busy=1, and raising out_ready delivers 7 then 3.
REQ-035 Assert rst=0 in RUN after 1 of 3 pairs, release, run len=1 pair (16,1) -> out_data=1 (stale sum cleared), no result from the aborted window.
REQ-036 start with len=0 -> in_ready never 1, out_data=0, out_sat=0, out_valid 4 cycles after start.
